// File: rtl/pipe_pkg.sv
// Shared pipeline package: datapath widths, writeback-select codes and
// the MEM/WB inter-stage bundle.
package pipe_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic RD_SEL_ALU = 1'b0;
  localparam logic RD_SEL_MEM = 1'b1;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd_waddr;
    logic                  rd_sel;
    logic                  rd_wena;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     dmem_data;
  } mem_wb_t;

endpackage

// File: rtl/pipe_retire_cnt.sv
// Free-running retired-instruction counter, wraps at 2^32.
// Built only when PIPE_MEM_WB_RETIRE_CNT_EN is defined.
module pipe_retire_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] cnt
);

  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_mem_wb.sv
// MEM/WB pipeline register and writeback mux.
// Optional retire counter: define PIPE_MEM_WB_RETIRE_CNT_EN.
module pipe_mem_wb #(
  parameter int DATA_W     = pipe_pkg::DATA_W,
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_valid,
  input  logic                  in_stall,
  input  logic                  in_flush,
  input  logic [REG_ADDR_W-1:0] in_rd_waddr,
  input  logic                  in_rd_sel,
  input  logic                  in_rd_wena,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_dmem_data,
  output logic                  out_valid,
  output logic                  out_rf_wena,
  output logic [REG_ADDR_W-1:0] out_rf_waddr,
  output logic [DATA_W-1:0]     out_rf_wdata
`ifdef PIPE_MEM_WB_RETIRE_CNT_EN
  ,
  output logic [31:0]           out_retired_cnt
`endif
);

  import pipe_pkg::*;

  mem_wb_t q;
  mem_wb_t d;

  // Flush only kills the control bits; data may stay stale.
  always_comb begin
    d = q;
    if (in_flush) begin
      d.valid   = 1'b0;
      d.rd_wena = 1'b0;
    end else if (!in_stall) begin
      d.valid      = in_valid;
      d.rd_waddr   = in_rd_waddr;
      d.rd_sel     = in_rd_sel;
      d.rd_wena    = in_rd_wena;
      d.alu_result = in_alu_result;
      d.dmem_data  = in_dmem_data;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

  assign out_valid    = q.valid;
  assign out_rf_wena  = q.valid & q.rd_wena & (q.rd_waddr != '0);
  assign out_rf_waddr = q.rd_waddr;
  assign out_rf_wdata = (q.rd_sel == RD_SEL_MEM) ? q.dmem_data
                                                 : q.alu_result;

`ifdef PIPE_MEM_WB_RETIRE_CNT_EN
  // The WB instruction leaves the stage on advance or flush.
  pipe_retire_cnt u_retire_cnt (
    .clk   (in_clk),
    .rst_n (in_rst_n),
    .inc   (q.valid & (~in_stall | in_flush)),
    .cnt   (out_retired_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_mem_wb.sv
// Self-checking bench for pipe_mem_wb: vector table, corner-case
// sequences and a randomized run against a behavioural model.
module tb_pipe_mem_wb;

  logic        clk;
  logic        rst_n;
  logic        valid, stall, flush;
  logic [4:0]  waddr;
  logic        sel, wena;
  logic [31:0] alu, dmem;
  logic        o_valid, o_wena;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
`ifdef PIPE_MEM_WB_RETIRE_CNT_EN
  logic [31:0] o_cnt;
`endif

  int n_chk;
  int n_fail;

  pipe_mem_wb dut (
    .in_clk        (clk),
    .in_rst_n      (rst_n),
    .in_valid      (valid),
    .in_stall      (stall),
    .in_flush      (flush),
    .in_rd_waddr   (waddr),
    .in_rd_sel     (sel),
    .in_rd_wena    (wena),
    .in_alu_result (alu),
    .in_dmem_data  (dmem),
    .out_valid     (o_valid),
    .out_rf_wena   (o_wena),
    .out_rf_waddr  (o_waddr),
    .out_rf_wdata  (o_wdata)
`ifdef PIPE_MEM_WB_RETIRE_CNT_EN
    ,
    .out_retired_cnt (o_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        sel;
    logic        wena;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic [31:0] dmem;
    logic        e_valid;
    logic        e_wena;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic fl,
                       input logic [4:0] a, input logic s,
                       input logic w, input logic [31:0] al,
                       input logic [31:0] dm);
    valid = v; stall = st; flush = fl;
    waddr = a; sel = s; wena = w;
    alu = al; dmem = dm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model of the WB stage contents
  logic        m_v, m_w, m_sel, m_known;
  logic [4:0]  m_a;
  logic [31:0] m_alu, m_dm;
  logic [31:0] m_cnt;

  task automatic model_edge();
    if (m_v && (!stall || flush)) m_cnt = m_cnt + 1;
    if (flush) begin
      m_v = 0; m_w = 0;
    end else if (!stall) begin
      m_v = valid; m_w = wena; m_sel = sel; m_a = waddr;
      m_alu = alu; m_dm = dmem; m_known = 1;
    end
  endtask

  task automatic model_chk(input string nm);
    chk({nm, ".valid"}, {31'd0, o_valid}, {31'd0, m_v});
    chk({nm, ".wena"}, {31'd0, o_wena},
        {31'd0, m_v && m_w && (m_a != 0)});
    if (m_known) begin
      chk({nm, ".waddr"}, {27'd0, o_waddr}, {27'd0, m_a});
      chk({nm, ".wdata"}, o_wdata, m_sel ? m_dm : m_alu);
    end
`ifdef PIPE_MEM_WB_RETIRE_CNT_EN
    chk({nm, ".cnt"}, o_cnt, m_cnt);
`endif
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    vecs[0] = '{1, 1, 1, 5'd8, 32'h10010004, 32'hDEADBEEF,
                1, 1, 32'hDEADBEEF};
    vecs[1] = '{1, 0, 1, 5'd0, 32'h5, 32'h0, 1, 0, 32'h5};
    vecs[2] = '{1, 0, 1, 5'd31, 32'hCAFEF00D, 32'h1234,
                1, 1, 32'hCAFEF00D};
    vecs[3] = '{1, 1, 0, 5'd7, 32'h1, 32'hA5A5A5A5,
                1, 0, 32'hA5A5A5A5};
    vecs[4] = '{0, 0, 1, 5'd9, 32'h77, 32'h88, 0, 0, 32'h77};
    vecs[5] = '{1, 1, 1, 5'd0, 32'h9, 32'hFFFFFFFF,
                1, 0, 32'hFFFFFFFF};

    #12;
    chk("rst.valid", {31'd0, o_valid}, 0);
    chk("rst.wena", {31'd0, o_wena}, 0);
    chk("rst.waddr", {27'd0, o_waddr}, 0);
    chk("rst.wdata", o_wdata, 0);
`ifdef PIPE_MEM_WB_RETIRE_CNT_EN
    chk("rst.cnt", o_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].v, 0, 0, vecs[i].waddr, vecs[i].sel,
            vecs[i].wena, vecs[i].alu, vecs[i].dmem);
      step();
      chk($sformatf("vec%0d.valid", i), {31'd0, o_valid},
          {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d.wena", i), {31'd0, o_wena},
          {31'd0, vecs[i].e_wena});
      chk($sformatf("vec%0d.waddr", i), {27'd0, o_waddr},
          {27'd0, vecs[i].waddr});
      chk($sformatf("vec%0d.wdata", i), o_wdata, vecs[i].e_wdata);
    end

    // Stall holds the stage for three cycles
    drive(1, 0, 0, 5'd3, 0, 1, 32'h11, 32'h0);
    step();
    chk("stall.cap.waddr", {27'd0, o_waddr}, 3);
    drive(1, 1, 0, 5'd4, 0, 1, 32'h22, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall%0d.waddr", k), {27'd0, o_waddr}, 3);
      chk($sformatf("stall%0d.wdata", k), o_wdata, 32'h11);
      chk($sformatf("stall%0d.wena", k), {31'd0, o_wena}, 1);
    end
    stall = 0;
    step();
    chk("unstall.waddr", {27'd0, o_waddr}, 4);
    chk("unstall.wdata", o_wdata, 32'h22);

    // Flush beats stall
    drive(1, 1, 1, 5'd6, 0, 1, 32'h66, 32'h0);
    step();
    chk("stflush.valid", {31'd0, o_valid}, 0);
    chk("stflush.wena", {31'd0, o_wena}, 0);
    drive(1, 0, 1, 5'd6, 0, 1, 32'h66, 32'h0);
    step();
    chk("flush.valid", {31'd0, o_valid}, 0);

    // Async reset mid-cycle with a live write
    drive(1, 0, 0, 5'd12, 0, 1, 32'h3C3C, 32'h0);
    step();
    chk("prerst.wena", {31'd0, o_wena}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.wena", {31'd0, o_wena}, 0);
    chk("arst.wdata", o_wdata, 0);
    chk("arst.valid", {31'd0, o_valid}, 0);
    chk("arst.waddr", {27'd0, o_waddr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 5'd2, 1, 1, 32'h0, 32'h600D);
    step();
    chk("postrst.wdata", o_wdata, 32'h600D);
    chk("postrst.wena", {31'd0, o_wena}, 1);

    m_v = 1; m_w = 1; m_sel = 1; m_a = 2;
    m_alu = 0; m_dm = 32'h600D; m_known = 1;
    m_cnt = 0;
`ifdef PIPE_MEM_WB_RETIRE_CNT_EN
    m_cnt = o_cnt;
    chk("cnt.after_rst", o_cnt, 0);
`endif

    // Randomized run against the model
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom, $urandom);
      model_edge();
      step();
      model_chk($sformatf("rnd%0d", k));
    end

`ifdef PIPE_MEM_WB_RETIRE_CNT_EN
    // Counter wrap from 0xFFFFFFFE with a live WB instruction
    drive(1, 0, 0, 5'd1, 0, 1, 32'h1, 32'h0);
    step();
    force dut.u_retire_cnt.cnt_q = 32'hFFFFFFFE;
    #1;
    release dut.u_retire_cnt.cnt_q;
    chk("wrap.forced", o_cnt, 32'hFFFFFFFE);
    step();
    chk("wrap.ff", o_cnt, 32'hFFFFFFFF);
    step();
    chk("wrap.zero", o_cnt, 32'h0);
    stall = 1;
    step();
    chk("wrap.stall", o_cnt, 32'h0);
    stall = 0;
    step();
    chk("wrap.resume", o_cnt, 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
